// File: rtl/seq_detect_pkg.sv
// Shared fill-state encoding and width helper for the serial pattern detector.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_ARMED   = 2'd2
    } fill_state_e;

    function automatic int len_width(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_detect_counter_sat_counter.sv
// Hit counter with clear; saturates with a sticky flag by default, or wraps with a
// one-cycle flag when SEQ_DETECT_CNT_WRAP_EN is defined.
module sat_counter
    import seq_detect_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SEQ_DETECT_CNT_WRAP_EN
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag marks the increment that rolls the count over.
    assign sat = inc & ~clr & (cnt_q == CNT_MAX);
`else
    logic sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else begin
            if (inc && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            sat_d = sat_q | (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`endif

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_counter.sv
// Runtime-loadable serial pattern detector with Moore/Mealy outputs and a hit counter.
// Define SEQ_DETECT_CNT_WRAP_EN to make the hit counter wrap instead of saturate.
module seq_detect_counter
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = len_width(PAT_W),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             y_mealy,
    output logic             y_moore,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cnt_sat
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             moore_q, moore_d;

    logic [PAT_W-1:0] hist_nx;
    logic [LEN_W-1:0] fill_nx;
    logic [PAT_W-1:0] len_mask;
    fill_state_e      st_nx;
    logic             len_ok;
    logic             match;

    // Match is judged on the history as it will look after this strobe.
    always_comb begin
        hist_nx = en ? {hist_q[PAT_W-2:0], a} : hist_q;
        fill_nx = (en && fill_q != FILL_MAX) ? fill_q + LEN_W'(1) : fill_q;

        if (fill_nx == '0) begin
            st_nx = ST_EMPTY;
        end else if (fill_nx < len_q) begin
            st_nx = ST_FILLING;
        end else begin
            st_nx = ST_ARMED;
        end

        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end

        len_ok = (len_q != '0) && (len_q <= FILL_MAX);
        match  = len_ok && (st_nx == ST_ARMED) && (((hist_nx ^ pat_q) & len_mask) == '0);
    end

    assign y_mealy = en & match & ~cfg_load;

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        moore_d = moore_q;
        if (cfg_load) begin
            pat_d   = pat;
            len_d   = pat_len;
            ovl_d   = overlap;
            hist_d  = '0;
            fill_d  = '0;
            moore_d = 1'b0;
        end else if (en) begin
            hist_d  = hist_nx;
            fill_d  = (match && !ovl_q) ? '0 : fill_nx;
            moore_d = y_mealy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            moore_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            moore_q <= moore_d;
        end
    end

    assign y_moore = moore_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (y_mealy),
        .clr (cnt_clr),
        .cnt (hit_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_counter.sv
// Scoreboard bench for seq_detect_counter: directed scenarios then randomized traffic.
module tb_seq_detect_counter;
    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, en, a, cfg_load, overlap, cnt_clr;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] pat_len;
    logic             y_mealy, y_moore, cnt_sat;
    logic [CNT_W-1:0] hit_cnt;

    always #5 clk = ~clk;

    seq_detect_counter #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .cfg_load(cfg_load), .pat(pat),
        .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr), .y_mealy(y_mealy),
        .y_moore(y_moore), .hit_cnt(hit_cnt), .cnt_sat(cnt_sat)
    );

    typedef struct {
        bit mealy;
        bit moore;
        int cnt;
        bit sat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_hits = 0;

    // Reference model: received bits (index 0 = newest), config and counter.
    bit         m_bits[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl, m_moore, m_sat;
    int         m_cnt;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endfunction

    exp_t mx;
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mx = sbq.pop_front();
            check("y_mealy", 32'(y_mealy), 32'(mx.mealy));
            check("y_moore", 32'(y_moore), 32'(mx.moore));
            check("hit_cnt", 32'(hit_cnt), mx.cnt);
            check("cnt_sat", 32'(cnt_sat), 32'(mx.sat));
        end
    end

    function automatic void model_reset();
        m_bits.delete();
        m_pat = '0; m_len = 0; m_ovl = 0; m_moore = 0; m_sat = 0; m_cnt = 0;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit av, input bit ld,
                       input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                       input bit ov, input bit cc);
        exp_t x;
        bit   hit;
        bit   tmp[$];
        rst = r; en = e; a = av; cfg_load = ld; pat = p; pat_len = l; overlap = ov; cnt_clr = cc;
        tmp = m_bits;
        tmp.push_front(av);
        if (tmp.size() > PAT_W) void'(tmp.pop_back());
        hit = 1'b0;
        if (e && !ld && m_len >= 1 && m_len <= PAT_W && tmp.size() >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++) if (tmp[i] != m_pat[i]) hit = 1'b0;
        end
        x.mealy = hit;
        x.moore = m_moore;
        x.cnt   = m_cnt;
`ifdef SEQ_DETECT_CNT_WRAP_EN
        x.sat   = hit && !cc && (m_cnt == CMAX);
`else
        x.sat   = m_sat;
`endif
        sbq.push_back(x);
        if (hit) n_hits++;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (ld) begin
                m_pat = p; m_len = int'(l); m_ovl = ov; m_moore = 0;
                m_bits.delete();
            end else if (e) begin
                m_bits = tmp;
                if (hit && !m_ovl) m_bits.delete();
                m_moore = hit;
            end
            if (cc) begin
                m_cnt = 0; m_sat = 0;
            end else if (hit) begin
`ifdef SEQ_DETECT_CNT_WRAP_EN
                m_cnt = (m_cnt + 1) % (CMAX + 1);
`else
                if (m_cnt < CMAX) m_cnt++;
                if (m_cnt == CMAX) m_sat = 1;
`endif
            end
        end
        #1;
    endtask

    task automatic bit_in(input bit av);
        cyc(0, 1, av, 0, '0, '0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input bit ov);
        cyc(0, 0, 0, 1, p, l, ov, 0);
    endtask

    task automatic clr();
        cyc(0, 0, 0, 0, '0, '0, 0, 1);
    endtask

    initial begin
        bit s1[] = '{1, 0, 1, 1, 0, 1, 1};
        rst = 1; en = 0; a = 0; cfg_load = 0; pat = '0; pat_len = '0; overlap = 0; cnt_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, '0, '0, 0, 0);
        idle();

        // Overlapping 1011 over 1,0,1,1,0,1,1 with idle gaps to show Moore hold.
        load(8'b1011, 4, 1);
        foreach (s1[i]) begin
            bit_in(s1[i]);
            if (i == 3) idle();
        end
        idle();
        // Same stream, non-overlapping.
        clr();
        load(8'b1011, 4, 0);
        foreach (s1[i]) bit_in(s1[i]);
        idle();
        // Load in the middle of a partial match; the concurrent bit is dropped.
        clr();
        load(8'b1011, 4, 1);
        bit_in(1); bit_in(0); bit_in(1);
        cyc(0, 1, 1, 1, 8'b1011, 4, 1, 0);
        bit_in(1);
        bit_in(0); bit_in(1); bit_in(1);
        // Zero length disables detection.
        load(8'hFF, 0, 1);
        repeat (6) bit_in(1);
        // Out-of-range length also disables detection.
        load(8'hFF, 9, 1);
        repeat (10) bit_in(1);
        // Full-width pattern.
        load(8'b1100_1010, 8, 1);
        bit_in(0); bit_in(1); bit_in(1); bit_in(0); bit_in(0); bit_in(1); bit_in(0); bit_in(1); bit_in(0);
        // Saturation with single-bit pattern.
        clr();
        load(8'b1, 1, 1);
        repeat (9) bit_in(1);
        idle();
        // Clear together with a hit.
        cyc(0, 1, 1, 0, '0, '0, 0, 1);
        bit_in(1);
        // Reset in the middle of a pattern.
        load(8'b1011, 4, 1);
        bit_in(1); bit_in(0); bit_in(1);
        cyc(1, 1, 1, 0, '0, '0, 0, 0);
        repeat (6) bit_in(1);
        load(8'b1011, 4, 1);
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            int unsigned rr;
            rr = $urandom_range(0, 999);
            if (rr < 3) begin
                cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, '0, '0, 0, 0);
            end else if (rr < 30) begin
                logic [LEN_W-1:0] l;
                l = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 10))
                                                : LEN_W'($urandom_range(1, 3));
                cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), 1,
                    PAT_W'($urandom), l, $urandom_range(0, 1), $urandom_range(0, 4) == 0);
            end else begin
                cyc(0, $urandom_range(0, 9) < 7, $urandom_range(0, 1), 0,
                    PAT_W'($urandom), LEN_W'($urandom), $urandom_range(0, 1),
                    $urandom_range(0, 49) == 0);
            end
        end

        en = 0; cfg_load = 0; cnt_clr = 0; rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", 32'(sbq.size()), 32'd0);
        if (n_hits == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL stimulus_hits: got %0d expected nonzero", n_hits);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
